// File: rtl/clock_pkg.sv
// Shared stopwatch definitions: display mode encodings, time word width and
// the default HOLD duration.
package clock_pkg;

    localparam int TIME_W           = 32;
    localparam int HOLD_CYC_DEFAULT = 100_000_000;

    localparam logic [1:0] MODE_LIVE   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_REVIEW = 2'd2;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: DEPTH x TIME_W words, one synchronous write port and one
// combinational read port.
module lap_ram
    import clock_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [TIME_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [TIME_W-1:0] rdata
);

    logic [TIME_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; lap_count decides which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recorder.sv
// Lap recorder between stopwatch and display: shows live time, freezes a
// just-taken lap for HOLD_CYC cycles, and lets the user step through stored laps.
module lap_recorder
    import clock_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = HOLD_CYC_DEFAULT,
    parameter int PW       = $clog2(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_data,
    input  logic              lap_pulse,
    input  logic              view_pulse,
    input  logic              clear,
    output logic [TIME_W-1:0] disp_data,
    output logic [1:0]        mode,
    output logic [CW-1:0]     lap_count,
    output logic [PW-1:0]     view_idx,
    output logic              full
);

    localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [1:0]        mode_q, mode_d;
    logic [TIME_W-1:0] disp_q, disp_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     oldest_q, oldest_d;
    logic [PW-1:0]     view_q, view_d;
    logic [HCW-1:0]    hold_q, hold_d;
    logic              we;
    logic              is_full;
    logic [PW-1:0]     rd_addr;
    logic [TIME_W-1:0] rd_data;

    assign is_full = (count_q == CW'(DEPTH));

    lap_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (we & ~rst),
        .waddr (wr_ptr_q),
        .wdata (time_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mode_d   = mode_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        oldest_d = oldest_q;
        view_d   = view_q;
        hold_d   = hold_q;
        we       = 1'b0;

        // Background HOLD countdown; any accepted strobe below overrides it.
        if (mode_q == MODE_HOLD) begin
            if (hold_q == '0) begin
                mode_d = MODE_LIVE;
            end else begin
                hold_d = hold_q - HCW'(1);
            end
        end

        if (clear) begin
            mode_d   = MODE_LIVE;
            count_d  = '0;
            wr_ptr_d = '0;
            oldest_d = '0;
            view_d   = '0;
            hold_d   = '0;
        end else if (lap_pulse) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (is_full) begin
                oldest_d = oldest_q + PW'(1);
            end else begin
                count_d = count_q + CW'(1);
            end
            if (mode_q != MODE_REVIEW) begin
                mode_d = MODE_HOLD;
                hold_d = HCW'(HOLD_CYC - 1);
            end
        end else if (view_pulse) begin
            if (mode_q == MODE_REVIEW) begin
                if (CW'(view_q) == count_q - CW'(1)) begin
                    mode_d = MODE_LIVE;
                    view_d = '0;
                end else begin
                    view_d = view_q + PW'(1);
                end
            end else if (count_q != '0) begin
                mode_d = MODE_REVIEW;
                view_d = '0;
                hold_d = '0;
            end
        end

        // Display shows the state being entered; a lap written this edge is
        // forwarded since the RAM only holds it after the edge.
        rd_addr = oldest_d + view_d;
        case (mode_d)
            MODE_HOLD:   disp_d = we ? time_data : disp_q;
            MODE_REVIEW: disp_d = (we && rd_addr == wr_ptr_q) ? time_data : rd_data;
            default:     disp_d = time_data;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_LIVE;
            disp_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            oldest_q <= '0;
            view_q   <= '0;
            hold_q   <= '0;
        end else begin
            mode_q   <= mode_d;
            disp_q   <= disp_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            oldest_q <= oldest_d;
            view_q   <= view_d;
            hold_q   <= hold_d;
        end
    end

    assign disp_data = disp_q;
    assign mode      = mode_q;
    assign lap_count = count_q;
    assign view_idx  = view_q;
    assign full      = is_full;

endmodule

// File: tb/tb_lap_recorder.sv
// Randomised and directed bench for lap_recorder with a queue-based reference
// model of the lap list and display behaviour.
module tb_lap_recorder;

    localparam int DEPTH    = 8;
    localparam int HOLD_CYC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] time_data = '0;
    logic        lap_pulse = 1'b0;
    logic        view_pulse = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] disp_data;
    logic [1:0]  mode;
    logic [3:0]  lap_count;
    logic [2:0]  view_idx;
    logic        full;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: laps kept oldest-first in a queue.
    logic [31:0] m_laps[$];
    int          m_mode = 0;
    int          m_view = 0;
    int          m_hold = 0;
    logic [31:0] m_disp = '0;

    always #5 clk = ~clk;

    lap_recorder #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_data  (time_data),
        .lap_pulse  (lap_pulse),
        .view_pulse (view_pulse),
        .clear      (clear),
        .disp_data  (disp_data),
        .mode       (mode),
        .lap_count  (lap_count),
        .view_idx   (view_idx),
        .full       (full)
    );

    task automatic model_update(input logic r, input logic [31:0] t,
                                input logic l, input logic v, input logic c);
        bit handled = 0;
        if (r) begin
            m_laps.delete();
            m_mode = 0; m_view = 0; m_hold = 0; m_disp = '0;
            return;
        end
        if (c) begin
            m_laps.delete();
            m_mode = 0; m_view = 0; m_hold = 0; m_disp = t;
            return;
        end
        if (l) begin
            m_laps.push_back(t);
            if (m_laps.size() > DEPTH) void'(m_laps.pop_front());
            if (m_mode != 2) begin
                m_mode = 1; m_hold = HOLD_CYC - 1; m_disp = t;
            end else begin
                m_disp = m_laps[m_view];
            end
            return;
        end
        if (v) begin
            if (m_mode == 2) begin
                handled = 1;
                if (m_view == m_laps.size() - 1) begin
                    m_mode = 0; m_view = 0; m_disp = t;
                end else begin
                    m_view++;
                    m_disp = m_laps[m_view];
                end
            end else if (m_laps.size() > 0) begin
                handled = 1;
                m_mode = 2; m_view = 0; m_hold = 0; m_disp = m_laps[0];
            end
        end
        if (!handled) begin
            case (m_mode)
                0: m_disp = t;
                1: if (m_hold == 0) begin m_mode = 0; m_disp = t; end
                   else m_hold--;
                default: m_disp = m_laps[m_view];
            endcase
        end
    endtask

    task automatic step(input logic r, input logic [31:0] t,
                        input logic l, input logic v, input logic c);
        rst = r; time_data = t; lap_pulse = l; view_pulse = v; clear = c;
        @(posedge clk);
        model_update(r, t, l, v, c);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if ({disp_data, mode, lap_count, view_idx, full} !== 42'd0) begin
            n_err++;
            $display("FAIL reset: disp=%h mode=%0d cnt=%0d idx=%0d full=%b, want all zero",
                     disp_data, mode, lap_count, view_idx, full);
        end
        step(1'b0, 32'h0001_2345, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (disp_data !== 32'h0001_2345 || mode !== 2'd0 || lap_count !== 4'd0) begin
            n_err++;
            $display("FAIL live_after_reset: disp=%h mode=%0d cnt=%0d, want 00012345/0/0",
                     disp_data, mode, lap_count);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 32'h0000_0512, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= HOLD_CYC + 1; i++) begin
            logic [31:0] want;
            logic [1:0]  want_mode;
            want      = (i < HOLD_CYC) ? 32'h0000_0512 : time_data;
            want_mode = (i < HOLD_CYC) ? 2'd1 : 2'd0;
            n_vec++;
            if (disp_data !== want || mode !== want_mode || lap_count !== 4'd1) begin
                n_err++;
                $display("FAIL hold[%0d]: disp=%h mode=%0d cnt=%0d, want %h/%0d/1",
                         i, disp_data, mode, lap_count, want, want_mode);
            end
            if (i < HOLD_CYC + 1) step(1'b0, $urandom | 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] laps_t [10];
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            laps_t[i] = $urandom;
            step(1'b0, laps_t[i], 1'b1, 1'b0, 1'b0);
        end
        n_vec++;
        if (full !== 1'b1 || lap_count !== 4'd8) begin
            n_err++;
            $display("FAIL wrap_full: full=%b cnt=%0d, want 1/8", full, lap_count);
        end
        for (int k = 0; k < 9; k++) begin
            step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (k < 8) begin
                if (disp_data !== laps_t[k+2] || mode !== 2'd2 || view_idx !== 3'(k)) begin
                    n_err++;
                    $display("FAIL review[%0d]: disp=%h mode=%0d idx=%0d, want %h/2/%0d",
                             k, disp_data, mode, view_idx, laps_t[k+2], k);
                end
            end else if (mode !== 2'd0 || disp_data !== time_data) begin
                n_err++;
                $display("FAIL review_exit: mode=%0d disp=%h, want 0/%h",
                         mode, disp_data, time_data);
            end
        end
    endtask

    task automatic test_view_empty();
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (mode !== 2'd0 || disp_data !== time_data || view_idx !== 3'd0) begin
                n_err++;
                $display("FAIL view_empty[%0d]: mode=%0d disp=%h idx=%0d, want 0/%h/0",
                         i, mode, disp_data, view_idx, time_data);
            end
        end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
        step(1'b0, $urandom, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (mode !== 2'd0 || lap_count !== 4'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL clear_lap: mode=%0d cnt=%0d full=%b, want 0/0/0",
                     mode, lap_count, full);
        end
        step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (mode !== 2'd0 || disp_data !== time_data) begin
            n_err++;
            $display("FAIL clear_no_lap: mode=%0d disp=%h, want 0/%h", mode, disp_data, time_data);
        end
    endtask

    task automatic test_reset_hold();
        step(1'b0, 32'h0000_0777, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (mode !== 2'd1 || disp_data !== 32'h0000_0777) begin
            n_err++;
            $display("FAIL pre_reset_hold: mode=%0d disp=%h, want 1/00000777", mode, disp_data);
        end
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (mode !== 2'd0 || disp_data !== 32'd0 || lap_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_in_hold: mode=%0d disp=%h cnt=%0d, want 0/0/0",
                     mode, disp_data, lap_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            logic r, l, v, c;
            r = ($urandom_range(255) == 0);
            c = ($urandom_range(63) == 0);
            l = ($urandom_range(7) == 0);
            v = ($urandom_range(3) == 0);
            step(r, $urandom, l, v, c);
            n_vec++;
            if (disp_data !== m_disp || mode !== 2'(m_mode) ||
                lap_count !== 4'(m_laps.size()) || view_idx !== 3'(m_view) ||
                full !== (m_laps.size() == DEPTH)) begin
                n_err++;
                $display("FAIL random[%0d]: disp=%h mode=%0d cnt=%0d idx=%0d full=%b, want %h/%0d/%0d/%0d/%b",
                         i, disp_data, mode, lap_count, view_idx, full,
                         m_disp, m_mode, m_laps.size(), m_view, (m_laps.size() == DEPTH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_wrap();
        test_view_empty();
        test_clear_priority();
        test_reset_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lap_recorder.md
LAP_RECORDER -- requirements
Module: lap_recorder

Interface
REQ-001 Parameter DEPTH, default 8, lap buffer entries (power of two, 2..16).
REQ-002 Parameter HOLD_CYC, default 100_000_000, HOLD display duration in clk cycles (2 s at 50 MHz).
REQ-003 clk  input  1  50 MHz system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 time_data  input  32  live BCD time from stopwatch, 8 digits.
REQ-006 lap_pulse  input  1  one-cycle strobe; record current time_data as a lap.
REQ-007 view_pulse  input  1  one-cycle strobe; enter or step lap review.
REQ-008 clear  input  1  one-cycle strobe; erase all laps, return to LIVE.
REQ-009 disp_data  output  32  BCD word to max7219_ctrl time_data input.
REQ-010 mode  output  2  current state: 0 LIVE, 1 HOLD, 2 REVIEW.
REQ-011 lap_count  output  clog2(DEPTH+1)  stored laps, saturating at DEPTH.
REQ-012 view_idx  output  clog2(DEPTH)  logical index shown in REVIEW (0 = oldest), else 0.
REQ-013 full  output  1  high when lap_count == DEPTH.

Function
REQ-014 disp_data SHALL be registered; it reflects inputs/state of the previous cycle (1-cycle latency).
REQ-015 LIVE: disp_data <= time_data every cycle.
REQ-016 lap_pulse SHALL write time_data to buffer at wr_ptr, advance wr_ptr modulo DEPTH, increment lap_count unless full.
REQ-017 When full, a new lap SHALL overwrite the oldest entry; oldest pointer advances; lap_count stays DEPTH.
REQ-018 lap_pulse in LIVE or HOLD SHALL enter HOLD, latch captured value to disp_data, reload hold counter to HOLD_CYC-1.
REQ-019 HOLD: counter decrements each cycle; at 0 and no other event, next state LIVE.
REQ-020 view_pulse in LIVE or HOLD with lap_count > 0 SHALL enter REVIEW with view_idx = 0; with lap_count == 0 it SHALL be ignored.
REQ-021 REVIEW: disp_data = entry at logical view_idx; view_pulse increments view_idx; view_pulse at view_idx == lap_count-1 SHALL return to LIVE.
REQ-022 lap_pulse in REVIEW SHALL record the lap, stay in REVIEW, keep view_idx; display updates to the entry now at that logical index.
REQ-023 Priority same cycle: clear > lap_pulse > view_pulse; lower-priority strobe is dropped.
REQ-024 clear SHALL zero lap_count, pointers, view_idx, enter LIVE; buffer contents need not be erased.
REQ-025 Buffer arithmetic SHALL wrap modulo DEPTH; logical index maps as (oldest_ptr + view_idx) mod DEPTH.
REQ-026 No combinational path from inputs to outputs.

Reset
REQ-027 On rst: mode = LIVE, disp_data = 0, lap_count = 0, view_idx = 0, full = 0, pointers = 0, hold counter = 0.
REQ-028 Reset mid-HOLD or mid-REVIEW SHALL abort to the REVIEW-027 values on the next edge; buffer RAM is not reset.
REQ-029 Strobes asserted in the reset cycle SHALL be ignored.

Structure
REQ-030 Shared package clock_pkg SHALL hold mode encodings (LIVE/HOLD/REVIEW), TIME_W = 32 and default HOLD_CYC.
REQ-031 Buffer SHALL be a sub-module lap_ram: DEPTH x 32, one write port, combinational read port.
REQ-032 lap_recorder contains the FSM, pointers, hold counter and output register only.

Verification
REQ-033 Reset, time_data = 32'h00_01_23_45 -> one cycle later disp_data = 32'h00012345, mode 0, lap_count 0.
REQ-034 lap_pulse with time_data = 32'h00000512, then time_data keeps changing -> disp_data holds 32'h00000512 for HOLD_CYC cycles (bench HOLD_CYC = 10), then follows time_data; lap_count 1.
REQ-035 Record 10 laps T0..T9 with DEPTH 8 -> full = 1, lap_count 8; view_pulse x8 shows T2..T9, 9th view_pulse -> mode 0.
REQ-036 view_pulse with lap_count 0 -> mode stays 0, disp_data tracks time_data.
REQ-037 clear and lap_pulse in same cycle while in REVIEW -> mode 0, lap_count 0, no lap stored.
REQ-038 rst asserted during HOLD with counter = 5 -> next cycle mode 0, disp_data 0, lap_count 0.
